// File: rtl/rising_edge_detect_if.sv
// rtl/rising_edge_detect_if.sv - monitored level and edge tick bundle
interface rising_edge_detect_if;
    logic level;
    logic tick_mealy;
    logic tick_moore;

    modport master (
        output level,
        input  tick_mealy,
        input  tick_moore
    );

    modport slave (
        input  level,
        output tick_mealy,
        output tick_moore
    );
endinterface

// File: rtl/rising_edge_detect.sv
// rtl/rising_edge_detect.sv - Mealy and Moore rising-edge detectors on one level input
module rising_edge_detect (
    input  logic                  clk,
    input  logic                  reset,
    rising_edge_detect_if.slave   bus
);
    typedef enum logic {
        MEALY_ZERO = 1'b0,
        MEALY_ONE  = 1'b1
    } mealy_state_t;

    typedef enum logic [1:0] {
        MOORE_ZERO = 2'b00,
        MOORE_EDGE = 2'b01,
        MOORE_ONE  = 2'b10
    } moore_state_t;

    mealy_state_t mealy_state;
    moore_state_t moore_state;
    logic         tick_moore_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mealy_state <= MEALY_ZERO;
        end else begin
            case (mealy_state)
                MEALY_ZERO: if (bus.level)  mealy_state <= MEALY_ONE;
                MEALY_ONE:  if (!bus.level) mealy_state <= MEALY_ZERO;
                default:                    mealy_state <= MEALY_ZERO;
            endcase
        end
    end

    // The Moore tick is registered alongside the state so it is high exactly in EDGE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            moore_state  <= MOORE_ZERO;
            tick_moore_q <= 1'b0;
        end else begin
            tick_moore_q <= 1'b0;
            case (moore_state)
                MOORE_ZERO: begin
                    if (bus.level) begin
                        moore_state  <= MOORE_EDGE;
                        tick_moore_q <= 1'b1;
                    end
                end
                MOORE_EDGE: begin
                    moore_state <= bus.level ? MOORE_ONE : MOORE_ZERO;
                end
                MOORE_ONE: begin
                    if (!bus.level) moore_state <= MOORE_ZERO;
                end
                default: begin
                    moore_state <= MOORE_ZERO;
                end
            endcase
        end
    end

    assign bus.tick_mealy = (mealy_state == MEALY_ZERO) && bus.level;
    assign bus.tick_moore = tick_moore_q;
endmodule

// File: tb/tb_rising_edge_detect.sv
// tb/tb_rising_edge_detect.sv - directed and random checks of both edge detectors
module tb_rising_edge_detect;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    bit   hist[$];

    rising_edge_detect_if bus ();

    rising_edge_detect dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs come from the history of levels sampled at rising edges.
    function automatic bit last_sample();
        return hist[hist.size()-1];
    endfunction

    function automatic bit exp_moore();
        return hist[hist.size()-1] && !hist[hist.size()-2];
    endfunction

    function automatic bit exp_mealy(input bit lv);
        return lv && !last_sample();
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic clear_hist();
        hist.delete();
        hist.push_back(1'b0);
        hist.push_back(1'b0);
    endtask

    task automatic step(input bit lv);
        @(negedge clk);
        #2 bus.level = lv;
        #1;
        chk("mealy_pre", bus.tick_mealy, exp_mealy(lv));
        chk("moore_pre", bus.tick_moore, exp_moore());
        @(posedge clk);
        hist.push_back(lv);
        #1;
        chk("mealy_post", bus.tick_mealy, exp_mealy(lv));
        chk("moore_post", bus.tick_moore, exp_moore());
    endtask

    task automatic glitch();
        bit prev_lv;
        @(negedge clk);
        prev_lv = bus.level;
        #2 bus.level = 1'b1;
        #1;
        chk("glitch_mealy_hi", bus.tick_mealy, exp_mealy(1'b1));
        #1 bus.level = 1'b0;
        #1;
        chk("glitch_mealy_lo", bus.tick_mealy, 1'b0);
        @(posedge clk);
        hist.push_back(1'b0);
        #1;
        chk("glitch_moore", bus.tick_moore, exp_moore());
        if (prev_lv) chk("glitch_mealy_post", bus.tick_mealy, 1'b0);
    endtask

    task automatic rise_then_drop();
        @(negedge clk);
        #2 bus.level = 1'b1;
        #1;
        chk("rd_mealy_hi", bus.tick_mealy, exp_mealy(1'b1));
        @(posedge clk);
        hist.push_back(1'b1);
        #1 bus.level = 1'b0;
        #1;
        chk("rd_mealy_lo", bus.tick_mealy, 1'b0);
        chk("rd_moore", bus.tick_moore, exp_moore());
    endtask

    // Called just after a rising edge; asserts and releases reset with no unmodelled sample.
    task automatic reset_pulse();
        #2 reset = 1'b0;
        clear_hist();
        #1;
        chk("rst_moore_async", bus.tick_moore, 1'b0);
        chk("rst_mealy_async", bus.tick_mealy, bus.level);
        @(posedge clk);
        #1;
        chk("rst_moore_hold", bus.tick_moore, 1'b0);
        chk("rst_mealy_hold", bus.tick_mealy, bus.level);
        #3 reset = 1'b1;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        reset     = 1'b0;
        bus.level = 1'b0;
        clear_hist();
        #1;
        chk("reset_moore", bus.tick_moore, 1'b0);
        chk("reset_mealy", bus.tick_mealy, 1'b0);
        @(posedge clk);
        #4 reset = 1'b1;

        for (int i = 0; i < 3; i++) step(1'b0);

        step(1'b1);
        step(1'b0);

        for (int i = 0; i < 5; i++) step(1'b1);
        step(1'b0);

        rise_then_drop();
        step(1'b0);

        step(1'b0);
        step(1'b1);
        reset_pulse();
        step(1'b1);
        step(1'b1);
        step(1'b0);

        for (int i = 0; i < 4; i++) step(i[0] ? 1'b0 : 1'b1);
        step(1'b0);

        glitch();
        step(1'b1);
        glitch();

        for (int i = 0; i < 120; i++) begin
            int unsigned r;
            r = $urandom_range(0, 11);
            if (r == 0)      glitch();
            else if (r == 1) reset_pulse();
            else             step(1'($urandom % 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rising_edge_detect.md
RISING_EDGE_DETECT -- requirements
Module: rising_edge_detect

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 1 bit.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; reset=0 forces both FSMs to their reset state immediately, independent of clk.
REQ-004 level  input  1  monitored signal, synchronous to clk; no internal synchroniser.
REQ-005 tick_mealy  output  1  Mealy-style rising-edge indication.
REQ-006 tick_moore  output  1  Moore-style rising-edge indication.

Function
REQ-007 The block SHALL contain two independent FSMs sharing clk, reset and level; neither FSM SHALL read the other's state.
REQ-008 Mealy FSM states SHALL be ZERO (level last sampled 0) and ONE (level last sampled 1).
REQ-009 Mealy transitions at each rising clk edge SHALL be: ZERO->ONE when level=1, ONE->ZERO when level=0, else hold.
REQ-010 tick_mealy SHALL be combinational: 1 exactly when state=ZERO and level=1, else 0; zero latency from level rising.
REQ-011 tick_mealy SHALL be 1 for the interval from level rising until the next rising clk edge samples level=1; a level pulse that rises and falls between two clock edges SHALL produce a tick_mealy glitch but no state change.
REQ-012 Moore FSM states SHALL be ZERO, EDGE and ONE.
REQ-013 Moore transitions at each rising clk edge SHALL be: ZERO->EDGE if level=1, else stay in ZERO; EDGE->ONE if level=1, EDGE->ZERO if level=0; ONE->ZERO if level=0, else stay in ONE.
REQ-014 tick_moore SHALL be 1 exactly when state=EDGE, giving a one-clock-cycle pulse that starts at the clock edge after level is sampled high.
REQ-015 tick_moore SHALL be glitch-free; it SHALL be a decode of registered state only.
REQ-016 level held high indefinitely SHALL produce exactly one tick on each output; no further tick SHALL occur until level is sampled 0 and then 1 again.
REQ-017 A level pulse sampled high for exactly one clock edge SHALL produce one tick_moore cycle and return the Moore FSM from EDGE to ZERO.
REQ-018 An unreachable or illegal state encoding SHALL recover to ZERO on the next clock edge.

Reset
REQ-019 While reset=0 both FSMs SHALL be in ZERO and tick_moore=0; tick_mealy SHALL equal level.
REQ-020 Reset asserted mid-operation, including while in EDGE or ONE, SHALL return both FSMs to ZERO asynchronously; after release, a level already high SHALL be treated as a new rising edge.
REQ-021 Deassertion of reset SHALL take effect at the first rising clk edge after reset returns to 1.

Verification
REQ-022 Reset applied, level=0 for 3 cycles -> tick_mealy=0, tick_moore=0 throughout.
REQ-023 level 0->1 at 2 ns after a falling edge, held 1 cycle -> tick_mealy=1 immediately until the next rising edge; tick_moore=1 for exactly the following cycle.
REQ-024 level held 1 for 5 cycles -> exactly one tick_mealy pulse and one tick_moore pulse, then both 0.
REQ-025 level rises at a falling edge and drops at the next rising edge -> tick_mealy pulses for half a cycle; Moore FSM follows whatever value the edge sampled, and no X appears on either output.
REQ-026 reset=0 asserted while Moore is in EDGE -> tick_moore drops to 0 at once; after release with level=1 -> one new tick on each output.
REQ-027 Back-to-back level toggling 1,0,1,0 per cycle -> tick_moore high on every cycle following each high sample; tick_mealy high during each high sample.
